// File: rtl/alu_div_sequencer_if.sv
// Divide sequencer request/response bundle.
// Request side handshakes on in_valid/in_ready, response on out_valid/out_ready.
interface alu_div_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  O;
  logic [1:0]  S;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;
  logic [31:0] F;

  modport master (
    output in_valid, A, B, O, S, flush, out_ready,
    input  in_ready, out_valid, R, F
  );

  modport slave (
    input  in_valid, A, B, O, S, flush, out_ready,
    output in_ready, out_valid, R, F
  );
endinterface

// File: rtl/alu_div_sequencer.sv
// Radix-2 restoring divide/modulo sequencer with RISC-V corner cases.
// Optional macro ALU_DIV_FASTPATH_EN: one-cycle bypass for trivial divides.
module alu_div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst_n,
  alu_div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   r_q, r_d;
  logic [3:0]        f_q, f_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              orem_q, orem_d;
  logic              sgn_q, sgn_d;
  logic              dz_q, dz_d;
  logic              ov_q, ov_d;

  logic              sa, sb, legal, dz, ov;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     shl, diff;
  logic              borrow;
  logic [XLEN-1:0]   q_fix, r_fix, res_fix;

  assign sa    = bus.S[0] & bus.A[XLEN-1];
  assign sb    = bus.S[1] & bus.B[XLEN-1];
  assign mag_a = sa ? (~bus.A + 1'b1) : bus.A;
  assign mag_b = sb ? (~bus.B + 1'b1) : bus.B;
  assign legal = (bus.O == 4'b0110) || (bus.O == 4'b0111);
  assign dz    = (bus.B == '0);
  assign ov    = (bus.S == 2'b11) &&
                 (bus.A == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (bus.B == {XLEN{1'b1}});

  assign shl    = {rem_q, quo_q[XLEN-1]};
  assign diff   = shl - {1'b0, dvs_q};
  assign borrow = diff[XLEN];

  // Sign fix-up and corner-case overrides applied after the last iteration
  always_comb begin
    q_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
    r_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
    if (dz_q) begin
      q_fix = {XLEN{1'b1}};
      r_fix = a_q;
    end
    res_fix = orem_q ? r_fix : q_fix;
  end

`ifdef ALU_DIV_FASTPATH_EN
  logic            fast;
  logic [XLEN-1:0] fast_r;

  // Results for operands that need no iteration
  always_comb begin
    fast   = dz || ov || (mag_a < mag_b);
    fast_r = '0;
    if (bus.O[0]) begin
      fast_r = ov ? '0 : bus.A;
    end else if (dz) begin
      fast_r = {XLEN{1'b1}};
    end else if (ov) begin
      fast_r = {1'b1, {(XLEN-1){1'b0}}};
    end
  end
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    r_d     = r_q;
    f_d     = f_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    orem_d  = orem_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = mag_a;
            dvs_d  = mag_b;
            a_d    = bus.A;
            qneg_d = sa ^ sb;
            rneg_d = sa;
            orem_d = bus.O[0];
            sgn_d  = |bus.S;
            dz_d   = dz;
            ov_d   = ov;
            if (!legal) begin
              state_d = DONE;
              r_d     = '0;
              f_d     = 4'b0100;
            end else begin
              state_d = ITER;
`ifdef ALU_DIV_FASTPATH_EN
              if (fast) begin
                state_d = DONE;
                r_d     = fast_r;
                f_d     = {(|bus.S) & fast_r[XLEN-1], 1'b0, ov, dz};
              end
`endif
            end
          end
        end
        ITER: begin
          rem_d = borrow ? shl[XLEN-1:0] : diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ~borrow};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
        end
        FIX: begin
          r_d     = res_fix;
          f_d     = {sgn_q & res_fix[XLEN-1], 1'b0, ov_q, dz_q};
          state_d = DONE;
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      r_q     <= '0;
      f_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      orem_q  <= 1'b0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      r_q     <= r_d;
      f_q     <= f_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      orem_q  <= orem_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.R         = r_q;
  assign bus.F         = {28'b0, f_q};

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Self-checking bench for alu_div_sequencer.
// Random and directed divides checked against an arithmetic model.
module tb_alu_div_sequencer;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] last_r;

  alu_div_sequencer_if bus ();

  alu_div_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  o,
    input  logic [1:0]  s,
    output logic [31:0] r,
    output logic [31:0] f,
    output int          lat
  );
    longint la, lb, q, rm, aa, ab;
    logic dzf, ovf, neg;
    la = s[0] ? longint'($signed(a)) : longint'(a);
    lb = s[1] ? longint'($signed(b)) : longint'(b);
    if (o != 4'd6 && o != 4'd7) begin
      r = 0; f = 32'd4; lat = 0;
      return;
    end
    dzf = (b == 0);
    ovf = (s == 2'b11) && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    if (dzf) begin
      q  = -1;
      rm = la;
    end else begin
      q  = la / lb;
      rm = la % lb;
    end
    r   = (o == 4'd7) ? rm[31:0] : q[31:0];
    neg = (s != 2'b00) && r[31];
    f   = {28'b0, neg, 1'b0, ovf, dzf};
    lat = 33;
    aa  = (la < 0) ? -la : la;
    ab  = (lb < 0) ? -lb : lb;
`ifdef ALU_DIV_FASTPATH_EN
    if (dzf || ovf || aa < ab) lat = 0;
`else
    if (aa < 0 || ab < 0) lat = -2;
`endif
  endfunction

  task automatic start_op(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] o, input logic [1:0] s
  );
    @(negedge clk);
    bus.A = a; bus.B = b; bus.O = o; bus.S = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic do_op(
    input  logic [31:0] a, input logic [31:0] b,
    input  logic [3:0] o, input logic [1:0] s,
    output logic [31:0] r, output logic [31:0] f,
    output int lat
  );
    start_op(a, b, o, s);
    lat = -1;
    for (int i = 0; i <= 60; i++) begin
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    r = bus.R;
    f = bus.F;
    @(negedge clk);
    if (lat < 0) bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.O = 0; bus.S = 0;
    bus.flush = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.in_ready, bus.out_valid, bus.R, bus.F} !== {1'b1, 1'b0, 64'b0})
      $display("FAIL reset: got rdy=%0b vld=%0b R=%h F=%h want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.R, bus.F);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [31:0] ta [9] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9,
                           32'h1234, 32'h1234, 32'h80000000, 32'h80000000, 32'd5};
    logic [31:0] tb [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3};
    logic [3:0]  to [9] = '{4'd6, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7, 4'd0};
    logic [1:0]  ts [9] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0};
    logic [31:0] er [9] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'd0, 32'd0};
    logic [31:0] ef [9] = '{32'd0, 32'd0, 32'd8, 32'd8, 32'd1, 32'd1,
                           32'hA, 32'd2, 32'd4};
    int el [9];
    logic [31:0] r, f;
    int lat;
    for (int i = 0; i < 9; i++) el[i] = 33;
    el[8] = 0;
`ifdef ALU_DIV_FASTPATH_EN
    for (int i = 4; i < 8; i++) el[i] = 0;
`endif
    for (int i = 0; i < 9; i++) begin
      do_op(ta[i], tb[i], to[i], ts[i], r, f, lat);
      total_cnt++;
      if (r !== er[i])
        $display("FAIL directed[%0d] R: got %h want %h", i, r, er[i]);
      else pass_cnt++;
      total_cnt++;
      if (f !== ef[i])
        $display("FAIL directed[%0d] F: got %h want %h", i, f, ef[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat !== el[i])
        $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, el[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, r, f, er, ef;
    logic [3:0] o;
    logic [1:0] s;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = $urandom_range(1, 15);
        1: b = 0;
        2: a = $urandom_range(0, 100);
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      o = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(6 + $urandom_range(0, 1));
      s = 2'($urandom);
      model(a, b, o, s, er, ef, el);
      do_op(a, b, o, s, r, f, lat);
      total_cnt++;
      if ({r, f} !== {er, ef} || lat !== el)
        $display("FAIL random a=%h b=%h o=%h s=%b: got R=%h F=%h lat=%0d want R=%h F=%h lat=%0d",
                 a, b, o, s, r, f, lat, er, ef, el);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    int got;
    start_op(32'd200, 32'd9, 4'd6, 2'd0);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.out_valid) got = 1;
      else begin @(posedge clk); #1; end
    end
    total_cnt++;
    if (got !== 1) $display("FAIL bp_timeout: got out_valid=0 want 1");
    else pass_cnt++;
    @(negedge clk);
    bus.A = 32'd77; bus.B = 32'd5; bus.O = 4'd6; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if ({bus.out_valid, bus.in_ready, bus.R, bus.F} !== {1'b1, 1'b0, 32'd22, 32'd0})
        $display("FAIL bp_hold[%0d]: got vld=%0b rdy=%0b R=%h F=%h want 1 0 16 0",
                 i, bus.out_valid, bus.in_ready, bus.R, bus.F);
      else pass_cnt++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    total_cnt++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL bp_release: got vld=%0b rdy=%0b want 0 1",
               bus.out_valid, bus.in_ready);
    else pass_cnt++;
    last_r = 32'd22;
  endtask

  task automatic test_flush;
    int rose;
    start_op(32'd1000, 32'd3, 4'd6, 2'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    total_cnt++;
    if ({bus.in_ready, bus.out_valid, bus.R} !== {1'b1, 1'b0, last_r})
      $display("FAIL flush_iter: got rdy=%0b vld=%0b R=%h want 1 0 %h",
               bus.in_ready, bus.out_valid, bus.R, last_r);
    else pass_cnt++;
    rose = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) rose = 1;
    end
    total_cnt++;
    if (rose !== 0) $display("FAIL flush_no_result: got out_valid rise want none");
    else pass_cnt++;
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    bus.A = 32'd50; bus.B = 32'd5; bus.O = 4'd6; bus.S = 2'd0;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    total_cnt++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL flush_idle: got in_ready=%0b want 1", bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop;
    logic [31:0] r, f;
    int lat;
    start_op(32'd1000, 32'd3, 4'd6, 2'd0);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.out_valid, bus.R, bus.F} !== 65'b0)
      $display("FAIL reset_midop: got vld=%0b R=%h F=%h want 0 0 0",
               bus.out_valid, bus.R, bus.F);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL reset_release: got in_ready=%0b want 1", bus.in_ready);
    else pass_cnt++;
    do_op(32'd100, 32'd7, 4'd6, 2'd0, r, f, lat);
    total_cnt++;
    if ({r, f} !== {32'd14, 32'd0} || lat !== 33)
      $display("FAIL reset_fresh: got R=%h F=%h lat=%0d want 0000000e 0 33", r, f, lat);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    last_r    = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_flush_idle();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
